// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings used by the pipeline stages.
package rv32i_pkg;

  // Write-back result select. Encoding 2'b11 is reserved and behaves as RES_ALU.
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // Load funct3 codes (width and signedness).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational load alignment/extension and misalignment detection.
// The memory returns the aligned word; this block picks the addressed
// byte or halfword and extends it according to funct3.
module load_extend
  import rv32i_pkg::*;
(
  input  logic        is_load,     // a valid load sits in the WB register
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,      // low address bits of the load
  input  logic [31:0] rdata,       // raw aligned memory word
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and halfword lanes.
  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend the selected lane; unsupported codes return the whole word.
  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data = {24'd0, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never fault.
  always_comb begin
    misaligned = 1'b0;
    if (is_load) begin
      if ((funct3 == F3_LH) || (funct3 == F3_LHU)) begin
        misaligned = offset[0];
      end else if (funct3 == F3_LW) begin
        misaligned = (offset != 2'd0);
      end
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, result mux, register-file
// write port, forwarding bus to EX and a retired-instruction counter.
// Outputs are driven combinationally from the register, so an instruction
// captured on one edge writes the register file during the following cycle.
module wb_stage
  import rv32i_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic                 in_reg_write,
  input  logic [4:0]           in_rd,
  input  logic [1:0]           in_result_src,
  input  logic [2:0]           in_funct3,
  input  logic [31:0]          in_alu_result,
  input  logic [31:0]          in_mem_rdata,
  input  logic [31:0]          in_pc_plus4,
  output logic                 rf_write_enable,
  output logic [4:0]           rf_address3,
  output logic [31:0]          rf_write_data,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [31:0]          fwd_data,
  output logic                 load_misaligned,
  output logic [CNT_WIDTH-1:0] retired_count
);

  logic                 valid_q,      valid_d;
  logic                 reg_write_q,  reg_write_d;
  logic [4:0]           rd_q,         rd_d;
  logic [1:0]           result_src_q, result_src_d;
  logic [2:0]           funct3_q,     funct3_d;
  logic [31:0]          alu_q,        alu_d;
  logic [31:0]          mem_q,        mem_d;
  logic [31:0]          pc4_q,        pc4_d;
  logic [CNT_WIDTH-1:0] retired_count_q, retired_count_d;

  logic        retire;
  logic [31:0] load_data;
  logic        misaligned;
  logic [31:0] result;

  // Next-state of the pipeline register: flush beats stall beats capture.
  // A flush only clears valid; the stale data fields are ignored afterwards.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    rd_d         = rd_q;
    result_src_d = result_src_q;
    funct3_d     = funct3_q;
    alu_d        = alu_q;
    mem_d        = mem_q;
    pc4_d        = pc4_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d      = in_valid;
      reg_write_d  = in_reg_write;
      rd_d         = in_rd;
      result_src_d = in_result_src;
      funct3_d     = in_funct3;
      alu_d        = in_alu_result;
      mem_d        = in_mem_rdata;
      pc4_d        = in_pc_plus4;
    end
  end

  // An entry retires on the edge where it leaves the register (also on a
  // flush, which overrides stall). Misaligned loads and x0 writes still count.
  always_comb begin
    retire          = valid_q & (~stall | flush);
    retired_count_d = retired_count_q + (retire ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q         <= 1'b0;
      reg_write_q     <= 1'b0;
      rd_q            <= 5'd0;
      result_src_q    <= 2'd0;
      funct3_q        <= 3'd0;
      alu_q           <= 32'd0;
      mem_q           <= 32'd0;
      pc4_q           <= 32'd0;
      retired_count_q <= '0;
    end else begin
      valid_q         <= valid_d;
      reg_write_q     <= reg_write_d;
      rd_q            <= rd_d;
      result_src_q    <= result_src_d;
      funct3_q        <= funct3_d;
      alu_q           <= alu_d;
      mem_q           <= mem_d;
      pc4_q           <= pc4_d;
      retired_count_q <= retired_count_d;
    end
  end

  load_extend u_load_extend (
    .is_load    (valid_q & (result_src_q == RES_MEM)),
    .funct3     (funct3_q),
    .offset     (alu_q[1:0]),
    .rdata      (mem_q),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  // Result mux; the reserved select value falls back to the ALU result.
  always_comb begin
    result = alu_q;
    case (result_src_q)
      RES_MEM: result = load_data;
      RES_PC4: result = pc4_q;
      default: result = alu_q;
    endcase
  end

  // Register-file port and forwarding bus. While stalled the same write
  // repeats every cycle, which is harmless for a register file.
  always_comb begin
    rf_write_enable = valid_q & reg_write_q & (rd_q != 5'd0) & ~misaligned;
    rf_address3     = rd_q;
    rf_write_data   = result;
    fwd_valid       = rf_write_enable;
    fwd_rd          = rf_address3;
    fwd_data        = rf_write_data;
    load_misaligned = misaligned;
    retired_count   = retired_count_q;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter CNT_WIDTH, default 32, sets the width of the retired-instruction counter.
REQ-002 The reset is rst_n, synchronous, active-low; the clock is clk.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 stall  input  1  hold the WB pipeline register.
REQ-006 flush  input  1  load a bubble into the WB pipeline register.
REQ-007 in_valid  input  1  MEM-stage instruction valid.
REQ-008 in_reg_write  input  1  instruction writes rd.
REQ-009 in_rd  input  5  destination register.
REQ-010 in_result_src  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-011 in_funct3  input  3  load width/sign code.
REQ-012 in_alu_result  input  32  ALU result; also the load address.
REQ-013 in_mem_rdata  input  32  raw aligned memory word.
REQ-014 in_pc_plus4  input  32  link value.
REQ-015 rf_write_enable  output  1  register-file write strobe.
REQ-016 rf_address3  output  5  register-file write address.
REQ-017 rf_write_data  output  32  register-file write data.
REQ-018 fwd_valid, fwd_rd[4:0], fwd_data[31:0]  output  forwarding bus to EX; same values as the rf_* outputs.
REQ-019 load_misaligned  output  1  misaligned-load pulse.
REQ-020 retired_count  output  CNT_WIDTH  count of retired instructions.

Function
REQ-021 On each posedge, the register update SHALL follow this priority: reset, then flush (valid_q<=0), then stall (hold all fields), otherwise capture all in_* fields.
REQ-022 Latency SHALL be one cycle: a captured instruction drives the rf_* outputs combinationally from the register in the following cycle.
REQ-023 rf_write_enable SHALL equal valid_q & reg_write_q & (rd_q!=0) & !load_misaligned.
REQ-024 fwd_valid SHALL equal rf_write_enable, and fwd_rd/fwd_data SHALL equal rf_address3/rf_write_data.
REQ-025 rf_write_data SHALL select by result_src: 00 gives alu_q; 01 gives the extended load; 10 gives pc4_q; 11 SHALL be treated as 00.
REQ-026 Load extraction uses offset = alu_q[1:0]:
- LB (000): sign-extended byte at offset*8.
- LBU (100): zero-extended byte at offset*8.
- LH (001): sign-extended halfword at offset[1]*16.
- LHU (101): zero-extended halfword at offset[1]*16.
- LW (010): the full word.
- Codes 011, 110 and 111: the full word.
REQ-027 load_misaligned SHALL be combinational and assert while valid_q & result_src_q==01 and either: LH/LHU with offset[0]=1, or LW with offset!=0. rf write is suppressed while it is asserted.
REQ-028 While stalled, an entry SHALL keep driving an identical write every cycle; this repeat is benign.
REQ-029 An instruction retires on the edge where it leaves the register: valid_q & (!stall | flush). retired_count SHALL increment by exactly 1 per retirement and wrap modulo 2^CNT_WIDTH.
REQ-030 A misaligned load SHALL still count as retired.
REQ-031 Simultaneous flush and stall: flush wins, and the current valid entry retires.
REQ-032 in_valid=0 SHALL capture a bubble; the other fields are don't-care.

Reset
REQ-033 While rst_n=0 at posedge, valid_q, all data fields and retired_count SHALL clear to 0.
REQ-034 Therefore all outputs SHALL be 0 the cycle after reset.
REQ-035 Reset asserted mid-stall SHALL discard the held entry without counting it.

Structure
REQ-036 Shared package rv32i_pkg SHALL hold:
- result_src enum: RES_ALU, RES_MEM, RES_PC4.
- funct3 load constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
REQ-037 A combinational sub-module load_extend SHALL implement REQ-026 and REQ-027.
REQ-038 The wb_stage module SHALL contain the pipeline register, the result mux and the retirement counter.

Verification
REQ-039 ALU write: rd=5, src=00, alu=0x1234_5678 -> next cycle rf_write_enable=1, addr=5, data=0x1234_5678, and retired_count becomes 1 at the following edge.
REQ-040 Byte loads: mem=0x80FF_7F01. LB off=3 -> 0xFFFF_FF80. LBU off=2 -> 0x0000_00FF. LH off=2 -> 0xFFFF_80FF.
REQ-041 Misaligned loads:
- LW, alu=0x1002 -> load_misaligned=1 and rf_write_enable=0.
- LH off=1 -> load_misaligned=1.
- LHU off=2 -> load_misaligned=0.
REQ-042 x0 and link:
- rd=0, reg_write=1 -> rf_write_enable=0, but the instruction still counts as retired.
- src=10, pc4=0x0000_0104 -> data=0x0000_0104.
REQ-043 Stall 3 cycles then flush+stall: outputs hold for 3 cycles, retired_count increments once at the flush edge, and valid_q=0 afterwards.
REQ-044 With CNT_WIDTH=4, 17 retirements -> retired_count=1; rst_n=0 during a stall -> all outputs 0 the next cycle.
